// File: rtl/board_b_pixel_mix.sv
// Board-B pixel mixer: per-pixel layer/object selection, palette lookup in three
// channel RAMs, blanking, and a CPU port arbitrated against video reads.
module board_b_pixel_mix #(
    parameter int PAL_AW = 9,
    parameter int CH_W   = 5
) (
    input  logic                CLK_32M,
    input  logic                reset,
    input  logic                CE_PIX,
    input  logic                HBLK,
    input  logic                VBLK,
    input  logic [3:0]          A_BIT,
    input  logic [3:0]          A_COL,
    input  logic                A_PRIO,
    input  logic [3:0]          B_BIT,
    input  logic [3:0]          B_COL,
    input  logic [3:0]          OBJ_BIT,
    input  logic [3:0]          OBJ_COL,
    input  logic [PAL_AW+1:0]   CPU_ADDR,
    input  logic [15:0]         CPU_DIN,
    input  logic                CPU_WR,
    input  logic                CPU_RD,
    output logic [15:0]         CPU_DOUT,
    output logic                CPU_RDY,
    output logic [CH_W-1:0]     R,
    output logic [CH_W-1:0]     G,
    output logic [CH_W-1:0]     B,
    output logic                HBLK_O,
    output logic                VBLK_O
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } arb_state_t;

    arb_state_t state, state_nx;

    logic [CH_W-1:0] ram_r [0:(1<<PAL_AW)-1];
    logic [CH_W-1:0] ram_g [0:(1<<PAL_AW)-1];
    logic [CH_W-1:0] ram_b [0:(1<<PAL_AW)-1];

    logic [PAL_AW-1:0] sel_idx, idx_s1;
    logic              hblk_s1, vblk_s1, hblk_s2, vblk_s2;
    logic [CH_W-1:0]   q_r, q_g, q_b;

    logic [1:0]        cpu_ch;
    logic [PAL_AW-1:0] cpu_idx;
    logic [CH_W-1:0]   cpu_rdata;
    logic              do_access;

    assign cpu_ch  = CPU_ADDR[PAL_AW+1:PAL_AW];
    assign cpu_idx = CPU_ADDR[PAL_AW-1:0];

    always_comb begin
        sel_idx = {1'b1, B_COL, B_BIT};
        if ((|A_BIT) && A_PRIO)
            sel_idx = {1'b1, A_COL, A_BIT};
        else if (|OBJ_BIT)
            sel_idx = {1'b0, OBJ_COL, OBJ_BIT};
        else if (|A_BIT)
            sel_idx = {1'b1, A_COL, A_BIT};
    end

    // Video reads only on CE_PIX cycles and CPU accesses only off them, so the
    // RAMs never see two ports in one cycle.
    always_ff @(posedge CLK_32M) begin
        if (CE_PIX) begin
            q_r <= ram_r[idx_s1];
            q_g <= ram_g[idx_s1];
            q_b <= ram_b[idx_s1];
        end
        if (do_access && CPU_WR) begin
            case (cpu_ch)
                2'd0:    ram_r[cpu_idx] <= CPU_DIN[CH_W-1:0];
                2'd1:    ram_g[cpu_idx] <= CPU_DIN[CH_W-1:0];
                2'd2:    ram_b[cpu_idx] <= CPU_DIN[CH_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            idx_s1  <= '0;
            hblk_s1 <= 1'b1;
            vblk_s1 <= 1'b1;
            hblk_s2 <= 1'b1;
            vblk_s2 <= 1'b1;
            R       <= '0;
            G       <= '0;
            B       <= '0;
            HBLK_O  <= 1'b1;
            VBLK_O  <= 1'b1;
        end else if (CE_PIX) begin
            idx_s1  <= sel_idx;
            hblk_s1 <= HBLK;
            vblk_s1 <= VBLK;
            hblk_s2 <= hblk_s1;
            vblk_s2 <= vblk_s1;
            HBLK_O  <= hblk_s2;
            VBLK_O  <= vblk_s2;
            if (hblk_s2 || vblk_s2) begin
                R <= '0;
                G <= '0;
                B <= '0;
            end else begin
                R <= q_r;
                G <= q_g;
                B <= q_b;
            end
        end
    end

    always_comb begin
        case (cpu_ch)
            2'd0:    cpu_rdata = ram_r[cpu_idx];
            2'd1:    cpu_rdata = ram_g[cpu_idx];
            2'd2:    cpu_rdata = ram_b[cpu_idx];
            default: cpu_rdata = '0;
        endcase
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_access = 1'b0;
        CPU_RDY   = 1'b0;
        case (state)
            ST_IDLE:
                if ((CPU_WR || CPU_RD) && !CE_PIX)
                    state_nx = ST_ACCESS;
            ST_ACCESS:
                if (!CE_PIX) begin
                    do_access = 1'b1;
                    state_nx  = ST_DONE;
                end
            ST_DONE: begin
                CPU_RDY = 1'b1;
                if (!CPU_WR && !CPU_RD)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read data is captured in the same cycle as any write, so a combined
    // write+read strobe returns the value held before the write.
    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset)
            CPU_DOUT <= '0;
        else if (do_access)
            CPU_DOUT <= {{(16-CH_W){1'b0}}, cpu_rdata};
    end

endmodule

// File: tb/tb_board_b_pixel_mix.sv
// Directed bench for board_b_pixel_mix: reset, CPU port, priority, latency,
// CPU/video contention and reset during an access.
module tb_board_b_pixel_mix;

    logic        CLK_32M;
    logic        reset;
    logic        CE_PIX;
    logic        HBLK, VBLK;
    logic [3:0]  A_BIT, A_COL, B_BIT, B_COL, OBJ_BIT, OBJ_COL;
    logic        A_PRIO;
    logic [10:0] CPU_ADDR;
    logic [15:0] CPU_DIN;
    logic        CPU_WR, CPU_RD;
    logic [15:0] CPU_DOUT;
    logic        CPU_RDY;
    logic [4:0]  R, G, B;
    logic        HBLK_O, VBLK_O;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int ce_per = 2;
    bit load_ok = 1'b1;
    logic [8:0] pix_exp [0:6];

    board_b_pixel_mix #(.PAL_AW(9), .CH_W(5)) dut (
        .CLK_32M(CLK_32M), .reset(reset), .CE_PIX(CE_PIX),
        .HBLK(HBLK), .VBLK(VBLK),
        .A_BIT(A_BIT), .A_COL(A_COL), .A_PRIO(A_PRIO),
        .B_BIT(B_BIT), .B_COL(B_COL),
        .OBJ_BIT(OBJ_BIT), .OBJ_COL(OBJ_COL),
        .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD),
        .CPU_DOUT(CPU_DOUT), .CPU_RDY(CPU_RDY),
        .R(R), .G(G), .B(B), .HBLK_O(HBLK_O), .VBLK_O(VBLK_O)
    );

    initial begin
        CLK_32M = 1'b0;
        forever #5 CLK_32M = ~CLK_32M;
    end

    function automatic logic [14:0] exp_rgb(input logic [8:0] i);
        logic [4:0] r, g, b;
        r = i[4:0];
        g = {i[8:5], i[0]};
        b = ~i[4:0];
        return {r, g, b};
    endfunction

    task automatic tick(output bit ce_was);
        bit c;
        c = (ce_per != 0) && ((cyc % ce_per) == 0);
        CE_PIX = c;
        @(posedge CLK_32M);
        #1;
        cyc++;
        ce_was = c;
    endtask

    task automatic cpu_access(input bit wr, input bit rd, input logic [10:0] addr,
                              input logic [15:0] din, output logic [15:0] dout,
                              output int lat, output bit ok);
        bit d;
        CPU_ADDR = addr;
        CPU_DIN  = din;
        CPU_WR   = wr;
        CPU_RD   = rd;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(d);
            lat++;
            if (CPU_RDY) begin
                ok = 1'b1;
                break;
            end
        end
        dout   = CPU_DOUT;
        CPU_WR = 1'b0;
        CPU_RD = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!CPU_RDY) break;
            tick(d);
        end
    endtask

    task automatic load_idx(input logic [8:0] idx);
        logic [14:0] v;
        logic [15:0] dout;
        int lat;
        bit ok;
        v = exp_rgb(idx);
        cpu_access(1'b1, 1'b0, {2'd0, idx}, {11'd0, v[14:10]}, dout, lat, ok);
        if (!ok) load_ok = 1'b0;
        cpu_access(1'b1, 1'b0, {2'd1, idx}, {11'd0, v[9:5]}, dout, lat, ok);
        if (!ok) load_ok = 1'b0;
        cpu_access(1'b1, 1'b0, {2'd2, idx}, {11'd0, v[4:0]}, dout, lat, ok);
        if (!ok) load_ok = 1'b0;
    endtask

    task automatic set_pix(input int k);
        A_BIT = 4'd0; A_COL = 4'd0; A_PRIO = 1'b0;
        OBJ_BIT = 4'd0; OBJ_COL = 4'd0; B_BIT = 4'd0; B_COL = 4'd0;
        case (k)
            0: begin A_BIT = 4'd5; A_COL = 4'd2; OBJ_BIT = 4'd3; OBJ_COL = 4'd1; end
            1: begin A_BIT = 4'd5; A_COL = 4'd2; A_PRIO = 1'b1; OBJ_BIT = 4'd3; OBJ_COL = 4'd1; end
            2: begin A_BIT = 4'd5; A_COL = 4'd2; end
            3: begin B_COL = 4'd7; end
            4: begin B_BIT = 4'd9; B_COL = 4'd4; end
            5: begin A_BIT = 4'd6; A_COL = 4'd3; B_BIT = 4'hF; B_COL = 4'hF; end
            6: begin A_PRIO = 1'b1; A_COL = 4'd3; OBJ_BIT = 4'd2; OBJ_COL = 4'hA; B_BIT = 4'd1; end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        bit d;
        ce_per = 2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick(d);
        checks++;
        if ({R, G, B} !== 15'd0 || HBLK_O !== 1'b1 || VBLK_O !== 1'b1 ||
            CPU_RDY !== 1'b0 || CPU_DOUT !== 16'd0)
            $display("FAIL reset_hold: rgb=%h hblk_o=%b vblk_o=%b rdy=%b dout=%h, want 0 1 1 0 0",
                     {R, G, B}, HBLK_O, VBLK_O, CPU_RDY, CPU_DOUT);
        else passes++;
        reset = 1'b0;
        tick(d);
        tick(d);
        checks++;
        if ({R, G, B} !== 15'd0 || HBLK_O !== 1'b1 || CPU_RDY !== 1'b0)
            $display("FAIL reset_release: rgb=%h hblk_o=%b rdy=%b, want 0 1 0",
                     {R, G, B}, HBLK_O, CPU_RDY);
        else passes++;
    endtask

    task automatic test_cpu_port();
        logic [15:0] dout;
        int lat;
        bit ok;
        ce_per = 4;
        cpu_access(1'b1, 1'b0, {2'd0, 9'h123}, 16'h0015, dout, lat, ok);
        checks++;
        if (!ok || lat > 4) $display("FAIL cpu_write_rdy: ok=%b latency=%0d, want 1 and <=4", ok, lat);
        else passes++;
        cpu_access(1'b0, 1'b1, {2'd0, 9'h123}, 16'h0000, dout, lat, ok);
        checks++;
        if (!ok || lat > 4 || dout !== 16'h0015)
            $display("FAIL cpu_read_r: ok=%b latency=%0d dout=%h, want 1 <=4 0015", ok, lat, dout);
        else passes++;
        cpu_access(1'b1, 1'b0, {2'd3, 9'h123}, 16'h001F, dout, lat, ok);
        cpu_access(1'b0, 1'b1, {2'd3, 9'h123}, 16'h0000, dout, lat, ok);
        checks++;
        if (!ok || dout !== 16'h0000)
            $display("FAIL cpu_read_ch3: ok=%b dout=%h, want 1 0000", ok, dout);
        else passes++;
        cpu_access(1'b0, 1'b1, {2'd0, 9'h123}, 16'h0000, dout, lat, ok);
        checks++;
        if (dout !== 16'h0015) $display("FAIL ch3_write_ignored: dout=%h, want 0015", dout);
        else passes++;
        cpu_access(1'b1, 1'b0, {2'd1, 9'h123}, 16'h000A, dout, lat, ok);
        cpu_access(1'b1, 1'b1, {2'd1, 9'h123}, 16'hFFFF, dout, lat, ok);
        checks++;
        if (!ok || dout !== 16'h000A)
            $display("FAIL wr_rd_prewrite: ok=%b dout=%h, want 1 000a", ok, dout);
        else passes++;
        cpu_access(1'b0, 1'b1, {2'd1, 9'h123}, 16'h0000, dout, lat, ok);
        checks++;
        if (dout !== 16'h001F) $display("FAIL wr_rd_written: dout=%h, want 001f", dout);
        else passes++;
    endtask

    task automatic test_priority();
        bit d;
        ce_per = 2;
        load_idx(9'h013); load_idx(9'h125); load_idx(9'h170);
        load_idx(9'h149); load_idx(9'h136); load_idx(9'h0A2);
        checks++;
        if (!load_ok) $display("FAIL palette_load: ok=%b, want 1", load_ok);
        else passes++;
        ce_per = 1;
        HBLK = 1'b0;
        VBLK = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_pix(k);
            for (int i = 0; i < 4; i++) tick(d);
            checks++;
            if ({R, G, B} !== exp_rgb(pix_exp[k]))
                $display("FAIL priority_%0d: rgb=%h, want %h (index %h)",
                         k, {R, G, B}, exp_rgb(pix_exp[k]), pix_exp[k]);
            else passes++;
        end
    endtask

    task automatic test_latency();
        bit ce;
        int n;
        logic [14:0] bg, imp, want;
        bg  = exp_rgb(9'h170);
        imp = exp_rgb(9'h125);
        ce_per = 2;
        set_pix(3);
        for (int i = 0; i < 8; i++) tick(ce);
        while ((cyc % ce_per) != 0) tick(ce);
        set_pix(1);
        tick(ce);
        set_pix(3);
        n = 1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            want = (n == 3) ? imp : bg;
            if ({R, G, B} !== want)
                $display("FAIL latency_step%0d: rgb=%h, want %h (ce pulses %0d)", i, {R, G, B}, want, n);
            else passes++;
            tick(ce);
            if (ce) n++;
        end
        while ((cyc % ce_per) != 0) tick(ce);
        HBLK = 1'b1;
        tick(ce);
        HBLK = 1'b0;
        n = 1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            want = (n == 3) ? 15'd0 : bg;
            if ({R, G, B} !== want || HBLK_O !== (n == 3))
                $display("FAIL hblank_step%0d: rgb=%h hblk_o=%b, want %h %b",
                         i, {R, G, B}, HBLK_O, want, (n == 3));
            else passes++;
            tick(ce);
            if (ce) n++;
        end
    endtask

    task automatic test_back_to_back();
        bit ce, strobe_on;
        int pc, wi;
        logic [8:0] h0, h1, cur;
        logic [15:0] dout;
        int lat;
        bit ok;
        ce_per = 2;
        set_pix(3);
        for (int i = 0; i < 8; i++) tick(ce);
        h0 = 9'h170;
        h1 = 9'h170;
        pc = 0;
        wi = 0;
        strobe_on = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wi == 8 && !strobe_on && !CPU_RDY) break;
            set_pix(pc);
            cur = pix_exp[pc];
            tick(ce);
            if (ce) begin
                checks++;
                if ({R, G, B} !== exp_rgb(h1))
                    $display("FAIL contention_video: rgb=%h, want %h (index %h)", {R, G, B}, exp_rgb(h1), h1);
                else passes++;
                h1 = h0;
                h0 = cur;
                pc = (pc + 1) % 7;
            end
            if (strobe_on && CPU_RDY) begin
                CPU_WR = 1'b0;
                strobe_on = 1'b0;
                wi++;
            end else if (!strobe_on && !CPU_RDY && wi < 8) begin
                CPU_ADDR = {2'd0, 9'h040 + 9'(wi)};
                CPU_DIN  = 16'((wi * 3 + 1) % 32);
                CPU_WR   = 1'b1;
                strobe_on = 1'b1;
            end
        end
        checks++;
        if (wi != 8) $display("FAIL contention_writes_done: done=%0d, want 8", wi);
        else passes++;
        for (int w = 0; w < 8; w++) begin
            cpu_access(1'b0, 1'b1, {2'd0, 9'h040 + 9'(w)}, 16'h0000, dout, lat, ok);
            checks++;
            if (!ok || dout !== 16'((w * 3 + 1) % 32))
                $display("FAIL contention_readback%0d: ok=%b dout=%h, want %h",
                         w, ok, dout, 16'((w * 3 + 1) % 32));
            else passes++;
        end
    endtask

    task automatic test_reset_in_access();
        bit d;
        logic [15:0] dout;
        int lat;
        bit ok;
        ce_per = 0;
        CPU_ADDR = {2'd0, 9'h050};
        CPU_DIN  = 16'h0011;
        CPU_WR   = 1'b1;
        tick(d);
        #2;
        reset  = 1'b1;
        CPU_WR = 1'b0;
        #1;
        checks++;
        if (CPU_RDY !== 1'b0) $display("FAIL rst_access_rdy: rdy=%b, want 0", CPU_RDY);
        else passes++;
        tick(d);
        tick(d);
        reset = 1'b0;
        tick(d);
        tick(d);
        checks++;
        if (CPU_RDY !== 1'b0 || HBLK_O !== 1'b1)
            $display("FAIL rst_access_after: rdy=%b hblk_o=%b, want 0 1", CPU_RDY, HBLK_O);
        else passes++;
        cpu_access(1'b1, 1'b0, {2'd0, 9'h050}, 16'h000C, dout, lat, ok);
        checks++;
        if (!ok) $display("FAIL rst_access_next_write: ok=%b, want 1", ok);
        else passes++;
        cpu_access(1'b0, 1'b1, {2'd0, 9'h050}, 16'h0000, dout, lat, ok);
        checks++;
        if (!ok || dout !== 16'h000C)
            $display("FAIL rst_access_next_read: ok=%b dout=%h, want 1 000c", ok, dout);
        else passes++;
    endtask

    initial begin
        pix_exp[0] = 9'h013; pix_exp[1] = 9'h125; pix_exp[2] = 9'h125;
        pix_exp[3] = 9'h170; pix_exp[4] = 9'h149; pix_exp[5] = 9'h136;
        pix_exp[6] = 9'h0A2;
        reset = 1'b1;
        CE_PIX = 1'b0;
        HBLK = 1'b1;
        VBLK = 1'b1;
        CPU_ADDR = '0;
        CPU_DIN = '0;
        CPU_WR = 1'b0;
        CPU_RD = 1'b0;
        set_pix(3);
        test_reset();
        test_cpu_port();
        test_priority();
        test_latency();
        test_back_to_back();
        test_reset_in_access();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
